// File: rtl/params.sv
// rtl/params.sv - transition mode codes and modulation field widths
package params;

  localparam logic [7:0] TRANSITION_MODE_SYNC_IDX  = 8'h00;
  localparam logic [7:0] TRANSITION_MODE_SYS_TIME  = 8'h01;
  localparam logic [7:0] TRANSITION_MODE_GPIO      = 8'h02;
  localparam logic [7:0] TRANSITION_MODE_EXT       = 8'hF0;
  localparam logic [7:0] TRANSITION_MODE_IMMEDIATE = 8'hFF;

  localparam int unsigned MOD_CYCLE_W = 15;
  localparam int unsigned MOD_REP_W   = 16;

endpackage

// File: rtl/settings.sv
// rtl/settings.sv - modulation settings record delivered by the controller
package settings;

  import params::*;

  typedef struct packed {
    logic                              UPDATE;
    logic                              REQ_RD_SEGMENT;
    logic [7:0]                        TRANSITION_MODE;
    logic [63:0]                       TRANSITION_VALUE;
    logic [1:0][MOD_CYCLE_W-1:0]       CYCLE;
    logic [1:0][MOD_REP_W-1:0]         REP;
  } mod_settings_t;

endpackage

// File: rtl/mod_segment_gpio_sync.sv
// rtl/mod_segment_gpio_sync.sv - 4-bit two-flop synchroniser with rising-edge detect
module mod_segment_gpio_sync (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] gpio_i,
  output logic [3:0] rise_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;
  logic [3:0] prev_q;

  // Two synchroniser stages followed by a history register for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= gpio_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/mod_segment_sequencer.sv
// rtl/mod_segment_sequencer.sv - modulation segment sequencer; GPIO trigger mode under MOD_SEGMENT_SEQUENCER_GPIO_EN
module mod_segment_sequencer #(
  parameter int unsigned CYCLE_W = 15,
  parameter logic [15:0] REP_INF = 16'hFFFF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  settings::mod_settings_t MOD_SETTINGS,
  input  logic [63:0]             SYS_TIME,
  input  logic [3:0]              GPIO_IN,
  input  logic                    SAMPLE_TICK,
  input  logic [CYCLE_W-1:0]      IDX,
  output logic                    SEGMENT,
  output logic                    SWAP,
  output logic                    STOP,
  output logic                    BAD_MODE
);

  import params::*;

`ifdef MOD_SEGMENT_SEQUENCER_GPIO_EN
  typedef enum logic [2:0] {
    ST_RUN, ST_WAIT_IDX, ST_WAIT_TIME, ST_WAIT_GPIO, ST_EXT_RUN
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_RUN, ST_WAIT_IDX, ST_WAIT_TIME, ST_EXT_RUN
  } state_e;
`endif

  state_e      state_q, state_d;
  logic        seg_q, seg_d;
  logic        swap_q, swap_d;
  logic        stop_q, stop_d;
  logic        bad_q, bad_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_seg_q, req_seg_d;
  logic [63:0] val_q, val_d;
  // go_q holds a swap decided on the previous edge; it lands on the next one.
  logic        go_q, go_d;
  logic        go_seg_q, go_seg_d;

  logic        loop_end;
  logic [15:0] rep_cur;
  logic        trig;
  logic        trig_seg;
  logic        upd_valid;

  assign loop_end = SAMPLE_TICK && (IDX == MOD_SETTINGS.CYCLE[seg_q][CYCLE_W-1:0]);
  assign rep_cur  = MOD_SETTINGS.REP[seg_q];

`ifdef MOD_SEGMENT_SEQUENCER_GPIO_EN
  logic [3:0] gpio_rise;
  logic       gpio_trig;

  mod_segment_gpio_sync u_gpio_sync (
    .CLK    (CLK),
    .RST    (RST),
    .gpio_i (GPIO_IN),
    .rise_o (gpio_rise)
  );

  assign gpio_trig = gpio_rise[val_q[1:0]];
`else
  logic unused_gpio;
  assign unused_gpio = ^GPIO_IN;
`endif

  // Register stage for state, pending request and the registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_RUN;
      seg_q     <= 1'b0;
      swap_q    <= 1'b0;
      stop_q    <= 1'b0;
      bad_q     <= 1'b0;
      cnt_q     <= '0;
      req_seg_q <= 1'b0;
      val_q     <= '0;
      go_q      <= 1'b0;
      go_seg_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      swap_q    <= swap_d;
      stop_q    <= stop_d;
      bad_q     <= bad_d;
      cnt_q     <= cnt_d;
      req_seg_q <= req_seg_d;
      val_q     <= val_d;
      go_q      <= go_d;
      go_seg_q  <= go_seg_d;
    end
  end

  // Next state: loop counting, wait triggers, update decode, then landing of a decided swap.
  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    swap_d    = 1'b0;
    stop_d    = stop_q;
    bad_d     = 1'b0;
    cnt_d     = cnt_q;
    req_seg_d = req_seg_q;
    val_d     = val_q;
    go_d      = 1'b0;
    go_seg_d  = go_seg_q;
    trig      = 1'b0;
    trig_seg  = req_seg_q;
    upd_valid = 1'b0;

    if (state_q != ST_EXT_RUN && !stop_q && loop_end) begin
      cnt_d = cnt_q + 16'd1;
      if (rep_cur != REP_INF && cnt_q == rep_cur) begin
        stop_d = 1'b1;
      end
    end

    case (state_q)
      ST_WAIT_IDX:  trig = loop_end && !stop_q;
      ST_WAIT_TIME: trig = (SYS_TIME >= val_q);
`ifdef MOD_SEGMENT_SEQUENCER_GPIO_EN
      ST_WAIT_GPIO: trig = gpio_trig;
`endif
      ST_EXT_RUN: begin
        trig     = loop_end;
        trig_seg = ~(go_q ? go_seg_q : seg_q);
      end
      default: trig = 1'b0;
    endcase

    if (trig) begin
      go_d     = 1'b1;
      go_seg_d = trig_seg;
      if (state_q != ST_EXT_RUN) begin
        state_d = ST_RUN;
      end
    end

    // A valid update discards any trigger found on this same edge.
    if (MOD_SETTINGS.UPDATE) begin
      upd_valid = 1'b1;
      case (MOD_SETTINGS.TRANSITION_MODE)
        TRANSITION_MODE_IMMEDIATE: begin
          go_d     = 1'b1;
          go_seg_d = MOD_SETTINGS.REQ_RD_SEGMENT;
          state_d  = ST_RUN;
        end
        TRANSITION_MODE_SYNC_IDX: begin
          if (stop_q) begin
            go_d     = 1'b1;
            go_seg_d = MOD_SETTINGS.REQ_RD_SEGMENT;
            state_d  = ST_RUN;
          end else begin
            go_d    = 1'b0;
            state_d = ST_WAIT_IDX;
          end
        end
        TRANSITION_MODE_SYS_TIME: begin
          go_d    = 1'b0;
          state_d = ST_WAIT_TIME;
        end
`ifdef MOD_SEGMENT_SEQUENCER_GPIO_EN
        TRANSITION_MODE_GPIO: begin
          go_d    = 1'b0;
          state_d = ST_WAIT_GPIO;
        end
`else
        TRANSITION_MODE_GPIO: begin
          bad_d     = 1'b1;
          upd_valid = 1'b0;
        end
`endif
        TRANSITION_MODE_EXT: begin
          go_d     = 1'b1;
          go_seg_d = MOD_SETTINGS.REQ_RD_SEGMENT;
          state_d  = ST_EXT_RUN;
        end
        default: begin
          bad_d     = 1'b1;
          upd_valid = 1'b0;
        end
      endcase
      if (upd_valid) begin
        req_seg_d = MOD_SETTINGS.REQ_RD_SEGMENT;
        val_d     = MOD_SETTINGS.TRANSITION_VALUE;
      end
    end

    // Landing a swap restarts loop accounting regardless of what counted above.
    if (go_q) begin
      seg_d  = go_seg_q;
      swap_d = 1'b1;
      cnt_d  = '0;
      stop_d = 1'b0;
    end
  end

  assign SEGMENT  = seg_q;
  assign SWAP     = swap_q;
  assign STOP     = stop_q;
  assign BAD_MODE = bad_q;

endmodule

// File: tb/tb_mod_segment_sequencer.sv
// tb/tb_mod_segment_sequencer.sv - bench for mod_segment_sequencer
module tb_mod_segment_sequencer;

  logic clk = 1'b0;
  logic rst;
  settings::mod_settings_t ms;
  logic [63:0] sys_time;
  logic [3:0]  gpio;
  logic        tick;
  logic [14:0] idx;
  logic        seg, swap, stop, bad;

  int checks = 0;
  int errors = 0;

`ifdef MOD_SEGMENT_SEQUENCER_GPIO_EN
  localparam logic GPIO_BAD = 1'b0;
`else
  localparam logic GPIO_BAD = 1'b1;
`endif

  mod_segment_sequencer dut (
    .CLK          (clk),
    .RST          (rst),
    .MOD_SETTINGS (ms),
    .SYS_TIME     (sys_time),
    .GPIO_IN      (gpio),
    .SAMPLE_TICK  (tick),
    .IDX          (idx),
    .SEGMENT      (seg),
    .SWAP         (swap),
    .STOP         (stop),
    .BAD_MODE     (bad)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mode;
    logic        req;
    logic [63:0] val;
    logic        e_bad;
    logic        e_sw1;
    logic        e_sw2;
    logic        e_seg;
  } vec_t;

  vec_t vt [8];

  // reference model state
  bit          m_seg, m_stop, m_land, m_land_seg, m_req;
  int          m_loops;
  int          m_kind;
  logic [63:0] m_val;
  bit          e_swap, e_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [7:0] mode, input logic req, input logic [63:0] val);
    ms.UPDATE           = 1'b1;
    ms.TRANSITION_MODE  = mode;
    ms.REQ_RD_SEGMENT   = req;
    ms.TRANSITION_VALUE = val;
    step();
    ms.UPDATE = 1'b0;
  endtask

  // ramp SYS_TIME by one per cycle; report the time sampled one edge before SWAP appeared
  task automatic ramp(output logic [63:0] hit);
    logic [63:0] last, t_at;
    hit  = '0;
    last = '0;
    for (int i = 0; i < 40; i++) begin
      t_at = sys_time;
      step();
      if (swap) begin
        hit = last;
        break;
      end
      last = t_at;
      sys_time++;
    end
  endtask

  // behavioural model: applies the transition rules for the edge about to happen
  task automatic model_edge();
    bit          le, old_stop, land, land_seg, fire;
    logic [15:0] rep_c;
    land     = m_land;
    land_seg = m_land_seg;
    m_land   = 0;
    old_stop = m_stop;
    le       = tick && (idx == ms.CYCLE[m_seg]);
    rep_c    = ms.REP[m_seg];
    e_swap   = 0;
    e_bad    = 0;
    if (le && !old_stop) begin
      if (rep_c != 16'hFFFF && m_loops == int'(rep_c)) m_stop = 1;
      m_loops++;
    end
    fire = (m_kind == 1 && le && !old_stop) || (m_kind == 2 && sys_time >= m_val);
    if (fire) begin
      m_land = 1; m_land_seg = m_req; m_kind = 0;
    end
    if (ms.UPDATE) begin
      if (ms.TRANSITION_MODE == 8'hFF || (ms.TRANSITION_MODE == 8'h00 && old_stop)) begin
        m_land = 1; m_land_seg = ms.REQ_RD_SEGMENT; m_kind = 0;
        m_req = ms.REQ_RD_SEGMENT; m_val = ms.TRANSITION_VALUE;
      end else if (ms.TRANSITION_MODE == 8'h00 || ms.TRANSITION_MODE == 8'h01) begin
        m_land = 0;
        m_kind = (ms.TRANSITION_MODE == 8'h00) ? 1 : 2;
        m_req = ms.REQ_RD_SEGMENT; m_val = ms.TRANSITION_VALUE;
      end else begin
        e_bad = 1;
      end
    end
    if (land) begin
      m_seg = land_seg; e_swap = 1; m_loops = 0; m_stop = 0;
    end
  endtask

  initial begin
    logic [63:0] hit;
    logic        seen;
    int          n_at;
    logic [7:0]  rmode;
    logic [15:0] reps [4];

    vt[0] = '{8'hFF, 1'b1, 64'd0,    1'b0,     1'b1, 1'b0, 1'b1};
    vt[1] = '{8'hFF, 1'b1, 64'd0,    1'b0,     1'b1, 1'b0, 1'b1};
    vt[2] = '{8'h55, 1'b0, 64'd0,    1'b1,     1'b0, 1'b0, 1'b1};
    vt[3] = '{8'h01, 1'b0, 64'd5,    1'b0,     1'b0, 1'b1, 1'b0};
    vt[4] = '{8'h01, 1'b1, 64'd2000, 1'b0,     1'b0, 1'b0, 1'b0};
    vt[5] = '{8'h02, 1'b1, 64'd0,    GPIO_BAD, 1'b0, 1'b0, 1'b0};
    vt[6] = '{8'h00, 1'b1, 64'd0,    1'b0,     1'b0, 1'b0, 1'b0};
    vt[7] = '{8'hFF, 1'b0, 64'd0,    1'b0,     1'b1, 1'b0, 1'b0};
    reps[0] = 16'd0; reps[1] = 16'd1; reps[2] = 16'd3; reps[3] = 16'hFFFF;

    ms = '0;
    ms.REP[0] = 16'hFFFF;
    ms.REP[1] = 16'hFFFF;
    sys_time = 64'd990;
    gpio = '0;
    tick = 1'b0;
    idx  = '0;
    rst  = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_segment", 32'(seg), 32'd0);
    check("reset_swap", 32'(swap), 32'd0);
    check("reset_stop", 32'(stop), 32'd0);
    check("reset_bad", 32'(bad), 32'd0);

    // single-update vectors from an idle sequencer
    for (int i = 0; i < 8; i++) begin
      upd(vt[i].mode, vt[i].req, vt[i].val);
      check($sformatf("vec%0d_bad", i), 32'(bad), 32'(vt[i].e_bad));
      step();
      check($sformatf("vec%0d_swap_t1", i), 32'(swap), 32'(vt[i].e_sw1));
      step();
      check($sformatf("vec%0d_swap_t2", i), 32'(swap), 32'(vt[i].e_sw2));
      check($sformatf("vec%0d_seg", i), 32'(seg), 32'(vt[i].e_seg));
    end

    // REP[0]=2: third loop end stops; SYNC_IDX while stopped swaps at once
    ms.REP[0] = 16'd2;
    ms.CYCLE[0] = 15'd0;
    tick = 1'b1;
    idx = 15'd0;
    step(); check("rep_loop1", 32'(stop), 32'd0);
    step(); check("rep_loop2", 32'(stop), 32'd0);
    step(); check("rep_loop3", 32'(stop), 32'd1);
    step(); check("rep_loop4", 32'(stop), 32'd1);
    tick = 1'b0;
    upd(8'h00, 1'b0, 64'd0);
    check("stop_sync_pre", 32'(stop), 32'd1);
    step();
    check("stop_sync_swap", {31'd0, swap}, 32'd1);
    check("stop_sync_clear", 32'(stop), 32'd0);
    ms.REP[0] = 16'hFFFF;

    // SYNC_IDX with CYCLE[0]=3
    ms.CYCLE[0] = 15'd3;
    upd(8'h00, 1'b1, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      idx = 15'(i);
      step();
      seen = seen | swap;
    end
    tick = 1'b0;
    check("sync_idx_early", 32'(seen), 32'd0);
    step();
    check("sync_idx_swap", 32'({swap, seg}), 32'b11);

    // SYS_TIME ramp to 1000
    upd(8'hFF, 1'b0, 64'd0);
    step();
    sys_time = 64'd990;
    upd(8'h01, 1'b1, 64'd1000);
    ramp(hit);
    check("time_ramp_hit", hit[31:0], 32'd1000);
    check("time_ramp_seg", 32'(seg), 32'd1);

    // invalid mode while a time swap is pending
    sys_time = 64'd100;
    upd(8'h01, 1'b0, 64'd105);
    upd(8'h55, 1'b1, 64'd0);
    check("bad_during_wait", 32'(bad), 32'd1);
    ramp(hit);
    check("bad_wait_hit", hit[31:0], 32'd105);
    check("bad_wait_seg", 32'(seg), 32'd0);

    // update on the same edge as a time match discards the match
    sys_time = 64'd200;
    upd(8'h01, 1'b1, 64'd203);
    sys_time = 64'd201; step();
    sys_time = 64'd202; step();
    sys_time = 64'd203;
    upd(8'h01, 1'b1, 64'd5000);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sys_time++;
      step();
      seen = seen | swap;
    end
    check("update_wins", 32'({seen, seg}), 32'b00);

    // EXT alternation with CYCLE=1 and REP=0
    ms.CYCLE[0] = 15'd1;
    ms.CYCLE[1] = 15'd1;
    ms.REP[0] = 16'd0;
    ms.REP[1] = 16'd0;
    upd(8'hF0, 1'b0, 64'd0);
    step();
    check("ext_start", 32'({swap, seg}), 32'b10);
    for (int k = 1; k <= 8; k++) begin
      tick = 1'b1;
      idx = 15'((k - 1) % 2);
      step();
      check($sformatf("ext_seg_k%0d", k), 32'({stop, seg}), 32'(((k - 1) / 2) % 2));
    end
    tick = 1'b0;
    upd(8'hFF, 1'b0, 64'd0);
    step();
    step();
    ms.REP[0] = 16'hFFFF;
    ms.REP[1] = 16'hFFFF;

`ifdef MOD_SEGMENT_SEQUENCER_GPIO_EN
    // GPIO trigger latency from pin edge
    upd(8'h02, 1'b1, 64'd2);
    step();
    gpio[2] = 1'b1;
    n_at = 0;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (swap && n_at == 0) n_at = n;
    end
    gpio = '0;
    check("gpio_latency", 32'(n_at), 32'd4);
`else
    n_at = 0;
`endif

    // reset in the middle of a wait
    upd(8'hFF, 1'b1, 64'd0);
    step();
    sys_time = 64'd300;
    upd(8'h01, 1'b0, 64'd303);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_midwait_seg", 32'({swap, seg}), 32'b00);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sys_time++;
      step();
      seen = seen | swap;
    end
    check("rst_midwait_noswap", 32'(seen), 32'd0);

    // randomized run against the model
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_seg = 0; m_stop = 0; m_land = 0; m_land_seg = 0; m_req = 0;
    m_loops = 0; m_kind = 0; m_val = '0;
    sys_time = 64'd1000;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) begin
        ms.REP[0] = reps[$urandom_range(0, 3)];
        ms.REP[1] = reps[$urandom_range(0, 3)];
      end
      case ($urandom_range(0, 4))
        0: rmode = 8'h00;
        1: rmode = 8'h01;
        2: rmode = 8'hFF;
        3: rmode = 8'h55;
        default: rmode = GPIO_BAD ? 8'h02 : 8'hA7;
      endcase
      ms.UPDATE = ($urandom_range(0, 7) == 0);
      ms.TRANSITION_MODE = rmode;
      ms.REQ_RD_SEGMENT = 1'($urandom_range(0, 1));
      ms.TRANSITION_VALUE = sys_time + 64'($urandom_range(0, 16)) - 64'd4;
      ms.CYCLE[0] = 15'($urandom_range(0, 3));
      ms.CYCLE[1] = 15'($urandom_range(0, 3));
      tick = 1'($urandom_range(0, 1));
      idx = 15'($urandom_range(0, 3));
      model_edge();
      step();
      check($sformatf("rnd_c%0d", c), 32'({seg, swap, stop, bad}),
            32'({m_seg, e_swap, m_stop, e_bad}));
      sys_time++;
    end
    ms.UPDATE = 1'b0;
    tick = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
